// File: rtl/mul_seq_16.sv
// Sequential 16x16 -> 32-bit unsigned shift-and-add multiplier.
// One shared adder_16 is stepped over 16 clocks per operation.

module adder_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  assign {cout, sum} = 17'(a) + 17'(b) + 17'(cin);
endmodule

module mul_seq_16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state;
  logic [15:0] m;
  logic [15:0] p_hi;
  logic [15:0] q;
  logic [3:0]  cnt;
  logic [15:0] addend;
  logic [15:0] sum;
  logic        cout;
  logic [31:0] next_pq;

  assign addend  = q[0] ? m : '0;
  assign next_pq = {cout, sum, q[15:1]};

  adder_16 u_add (
    .a    (p_hi),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      m       <= '0;
      p_hi    <= '0;
      q       <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            m     <= a;
            q     <= b;
            p_hi  <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        CALC: begin
          // carry from the adder becomes bit 31 of the shifted {p_hi, q}
          {p_hi, q} <= next_pq;
          cnt       <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            product <= next_pq;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mul_seq_16.sv
// Scoreboard bench for mul_seq_16: driver queues hand-computed products,
// monitor pops and compares whenever done is seen.

module tb_mul_seq_16;
  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [31:0] product;

  typedef struct {
    logic [31:0] prod;
    int unsigned acc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned busy_cnt = 0;
  logic [31:0] held = '0;

  mul_seq_16 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      held     = '0;
      busy_cnt = 0;
    end else if (done) begin
      check("done_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("product", product, e.prod);
        check("latency", cyc - e.acc, 32'd16);
        check("busy_run", busy_cnt, 32'd16);
        check("busy_in_done", 32'(busy), 32'd0);
        held = e.prod;
      end
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      check("product_hold", product, held);
    end
  end

  task automatic issue(input logic [15:0] x, input logic [15:0] y, input logic [31:0] p);
    @(posedge clk);
    #1;
    a     = x;
    b     = y;
    start = 1'b1;
    sb.push_back('{prod: p, acc: cyc + 1});
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("drain_timeout", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    int unsigned first;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_product", product, 32'd0);
    #5 rst_n = 1'b1;

    issue(16'd3, 16'd5, 32'h0000000F);
    drain();
    issue(16'hFFFF, 16'hFFFF, 32'hFFFE0001);
    drain();
    issue(16'h0000, 16'hABCD, 32'h00000000);
    drain();
    issue(16'h1234, 16'h0000, 32'h00000000);
    drain();

    // second start mid-CALC must be ignored
    issue(16'd7, 16'd9, 32'd63);
    repeat (3) @(posedge clk);
    #1;
    a = 16'd2; b = 16'd2; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    drain();
    repeat (20) @(posedge clk);

    // start held high: accept again in the DONE cycle
    @(posedge clk);
    #1;
    a = 16'd10; b = 16'd10; start = 1'b1;
    first = cyc + 1;
    sb.push_back('{prod: 32'd100, acc: first});
    @(posedge clk);
    #1;
    a = 16'd100; b = 16'd3;
    sb.push_back('{prod: 32'd300, acc: first + 17});
    repeat (17) @(posedge clk);
    #1;
    start = 1'b0;
    drain();

    // asynchronous reset in the middle of CALC
    issue(16'h8000, 16'h0002, 32'h00010000);
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_busy", 32'(busy), 32'd0);
    check("async_done", 32'(done), 32'd0);
    check("async_product", product, 32'd0);
    #4;
    rst_n = 1'b1;
    repeat (25) @(posedge clk);
    issue(16'h8000, 16'h0002, 32'h00010000);
    drain();
    repeat (5) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
